// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the data memory responder.
//   dm_state_e  - block-access FSM states
//   byte_mask() - byte enables for a sized word write at a byte offset
package dm_pkg;

    localparam int BLOCK_BITS      = 256;
    localparam int WORD_BITS       = 32;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int BYTES_PER_WORD  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Size 0 encodes a full word. Shifting an 8-bit mask and keeping the low
    // nibble drops any bytes that would fall past the word boundary.
    function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [7:0] m;
        case (size)
            2'd1:    m = 8'h01;
            2'd2:    m = 8'h03;
            2'd3:    m = 8'h07;
            default: m = 8'h0F;
        endcase
        m = m << off;
        return m[3:0];
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: requester <-> data memory bus.
//   master : requester side (drives address, word and block requests)
//   slave  : memory side (returns word/block data and completion pulses)
interface data_mem_responder_if import dm_pkg::*; ();

    logic [31:0]             data_address_2DM;
    logic                    MemRead_2DM;
    logic                    MemWrite_2DM;
    logic [WORD_BITS-1:0]    data_write_2DM;
    logic [1:0]              data_write_size_2DM;
    logic [WORD_BITS-1:0]    data_read_fDM;
    logic                    dBlkRead;
    logic                    dBlkWrite;
    logic [BLOCK_BITS-1:0]   block_write_2DM;
    logic [BLOCK_BITS-1:0]   block_read_fDM;
    logic                    block_read_fDM_valid;
    logic                    block_write_fDM_valid;

    modport master (
        output data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
               data_write_size_2DM, dBlkRead, dBlkWrite, block_write_2DM,
        input  data_read_fDM, block_read_fDM, block_read_fDM_valid,
               block_write_fDM_valid
    );

    modport slave (
        input  data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
               data_write_size_2DM, dBlkRead, dBlkWrite, block_write_2DM,
        output data_read_fDM, block_read_fDM, block_read_fDM_valid,
               block_write_fDM_valid
    );

endinterface

// File: rtl/dm_byte_store.sv
// dm_byte_store: DEPTH_BLOCKS x 256-bit storage addressed as 32-bit words.
//   word_*  - byte-enabled word write, combinational word read
//   blk_*   - whole-block write, combinational block read (same index)
// Storage is not reset.
module dm_byte_store import dm_pkg::*; #(
    parameter int DEPTH_BLOCKS = 16,
    localparam int IDX_W       = $clog2(DEPTH_BLOCKS),
    localparam int WADDR_W     = IDX_W + 3
) (
    input  logic                  CLK,
    input  logic [WADDR_W-1:0]    word_addr,
    input  logic                  word_we,
    input  logic [3:0]            word_be,
    input  logic [WORD_BITS-1:0]  word_wdata,
    output logic [WORD_BITS-1:0]  word_rdata,
    input  logic [IDX_W-1:0]      blk_idx,
    input  logic                  blk_we,
    input  logic [BLOCK_BITS-1:0] blk_wdata,
    output logic [BLOCK_BITS-1:0] blk_rdata
);

    logic [WORD_BITS-1:0] mem [DEPTH_BLOCKS*WORDS_PER_BLOCK];

    // Word write is applied after the block write so that, on a shared
    // edge, the enabled word bytes override the block data.
    always_ff @(posedge CLK) begin
        if (blk_we) begin
            for (int w = 0; w < WORDS_PER_BLOCK; w++)
                mem[{blk_idx, 3'(w)}] <= blk_wdata[w*WORD_BITS +: WORD_BITS];
        end
        if (word_we) begin
            for (int b = 0; b < BYTES_PER_WORD; b++)
                if (word_be[b]) mem[word_addr][b*8 +: 8] <= word_wdata[b*8 +: 8];
        end
    end

    assign word_rdata = mem[word_addr];

    for (genvar w = 0; w < WORDS_PER_BLOCK; w++) begin : g_blk_rd
        assign blk_rdata[w*WORD_BITS +: WORD_BITS] = mem[{blk_idx, 3'(w)}];
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data memory with immediate word access and a
// fixed-latency block read/write port.
//   CLK, RESET (async, active low)
//   bus : data_mem_responder_if.slave
// Word reads/writes are serviced every cycle. A block request is accepted in
// IDLE (write has priority), responds LATENCY cycles later with a one-cycle
// valid pulse; a block write lands in the array as RESP is left.
module data_mem_responder import dm_pkg::*; #(
    parameter int LATENCY      = 4,
    parameter int DEPTH_BLOCKS = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_BLOCKS);

    dm_state_e             state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
    logic [BLOCK_BITS-1:0] held_q, held_d;
    logic                  rvld_q, rvld_d;
    logic                  wvld_q, wvld_d;

    logic                  blk_we;
    logic [BLOCK_BITS-1:0] blk_rdata;
    logic [WORD_BITS-1:0]  word_rdata;
    logic [IDX_W-1:0]      addr_idx;
    logic                  unused_addr;

    assign addr_idx    = bus.data_address_2DM[4+IDX_W:5];
    assign unused_addr = ^bus.data_address_2DM[31:5+IDX_W];

    dm_byte_store #(.DEPTH_BLOCKS(DEPTH_BLOCKS)) u_store (
        .CLK        (CLK),
        .word_addr  (bus.data_address_2DM[4+IDX_W:2]),
        .word_we    (bus.MemWrite_2DM),
        .word_be    (byte_mask(bus.data_write_size_2DM, bus.data_address_2DM[1:0])),
        .word_wdata (bus.data_write_2DM << {bus.data_address_2DM[1:0], 3'b000}),
        .word_rdata (word_rdata),
        .blk_idx    (idx_q),
        .blk_we     (blk_we),
        .blk_wdata  (wdata_q),
        .blk_rdata  (blk_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        held_d  = held_q;
        rvld_d  = 1'b0;
        wvld_d  = 1'b0;
        blk_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.dBlkWrite) begin
                    idx_d   = addr_idx;
                    wdata_d = bus.block_write_2DM;
                    wr_d    = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_BUSY;
                end else if (bus.dBlkRead) begin
                    idx_d   = addr_idx;
                    wr_d    = 1'b0;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Counter starts at LATENCY-1, so RESP is entered exactly
                // LATENCY edges after acceptance; valids align with RESP.
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    rvld_d  = ~wr_q;
                    wvld_d  = wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (wr_q) blk_we = 1'b1;
                else      held_d = blk_rdata;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            held_q  <= '0;
            rvld_q  <= 1'b0;
            wvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            held_q  <= held_d;
            rvld_q  <= rvld_d;
            wvld_q  <= wvld_d;
        end
    end

    // Block data is live from the array during a read RESP so it includes
    // every word write committed up to RESP entry; otherwise the last value.
    assign bus.block_read_fDM        = (state_q == ST_RESP && !wr_q) ? blk_rdata : held_q;
    assign bus.block_read_fDM_valid  = rvld_q;
    assign bus.block_write_fDM_valid = wvld_q;
    assign bus.data_read_fDM         = bus.MemRead_2DM ? word_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized + directed checks of data_mem_responder
// against a word-array reference model.
module tb_data_mem_responder;
    import dm_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 16;
    localparam int NW    = DEPTH * 8;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    data_mem_responder_if dif ();

    data_mem_responder #(.LATENCY(LAT), .DEPTH_BLOCKS(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (dif)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0]  mem_m [NW];
    logic [255:0] last_rd;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % NW);
    endfunction

    function automatic void m_word_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int n, off, wi;
        n   = (sz == 2'd0) ? 4 : int'(sz);
        off = int'(a % 4);
        wi  = widx(a);
        for (int k = 0; k < n; k++)
            if (off + k < 4) mem_m[wi][8*(off+k) +: 8] = d[8*k +: 8];
    endfunction

    function automatic logic [255:0] m_blk(input int b);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = mem_m[b*8 + w];
        return r;
    endfunction

    function automatic void m_blk_wr(input int b, input logic [255:0] d);
        for (int w = 0; w < 8; w++) mem_m[b*8 + w] = d[32*w +: 32];
    endfunction

    function automatic logic [255:0] rand_blk();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    task automatic set_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        dif.data_address_2DM    = a;
        dif.data_write_2DM      = d;
        dif.data_write_size_2DM = sz;
        dif.MemWrite_2DM        = 1'b1;
    endtask

    // One clock: update the model for whatever commits at this edge, then
    // return at the following falling edge where outputs are sampled.
    task automatic cyc(input bit commit, input int b, input logic [255:0] d);
        @(posedge CLK);
        if (commit && RESET) m_blk_wr(b, d);
        if (dif.MemWrite_2DM && RESET)
            m_word_wr(dif.data_address_2DM, dif.data_write_2DM, dif.data_write_size_2DM);
        @(negedge CLK);
        dif.MemWrite_2DM = 1'b0;
    endtask

    task automatic word_rd_chk(input string tag, input logic [31:0] a);
        dif.data_address_2DM = a;
        dif.MemRead_2DM      = 1'b1;
        #1;
        chk(tag, dif.data_read_fDM, mem_m[widx(a)]);
        dif.MemRead_2DM = 1'b0;
        #1;
        chk({tag, "_off"}, dif.data_read_fDM, 32'h0);
    endtask

    // Full block transaction. fix_k selects the cycle (1..LAT+1, LAT+1 being
    // the response cycle) for a fixed word write; 0 disables it. rnd adds
    // random word writes on other cycles.
    task automatic blk_op(input bit wr, input bit keep_rd, input logic [31:0] a,
                          input logic [255:0] d, input bit rnd, input int fix_k,
                          input logic [31:0] fwa, input logic [31:0] fwd, input string tag);
        int b;
        b = widx(a) / 8;
        dif.data_address_2DM = a;
        dif.block_write_2DM  = d;
        dif.dBlkWrite        = wr;
        dif.dBlkRead         = !wr || keep_rd;
        cyc(0, 0, '0);
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k == LAT + 1) begin
                dif.dBlkWrite = 1'b0;
                dif.dBlkRead  = keep_rd;
            end
            if (k == fix_k)
                set_wr(fwa, fwd, 2'd0);
            else if (rnd && $urandom_range(0, 1) == 1)
                set_wr(($urandom() & 32'hFFFF_FE00) | (32'(b) * 32) | $urandom_range(0, 31),
                       $urandom(), 2'($urandom_range(0, 3)));
            cyc(wr && k == LAT + 1, b, d);
            if (k < LAT) begin
                chk({tag, "_busy_vld"}, {dif.block_read_fDM_valid, dif.block_write_fDM_valid}, 2'b00);
            end else if (k == LAT) begin
                chk({tag, "_wvld"}, dif.block_write_fDM_valid, wr);
                chk({tag, "_rvld"}, dif.block_read_fDM_valid, !wr);
                if (!wr) begin
                    chk({tag, "_data"}, dif.block_read_fDM, m_blk(b));
                    last_rd = m_blk(b);
                end
            end else begin
                chk({tag, "_end_vld"}, {dif.block_read_fDM_valid, dif.block_write_fDM_valid}, 2'b00);
                chk({tag, "_hold"}, dif.block_read_fDM, last_rd);
            end
        end
    endtask

    initial begin
        logic [255:0] pat, prior, bd;
        logic [31:0]  ra;

        dif.data_address_2DM    = '0;
        dif.MemRead_2DM         = 1'b0;
        dif.MemWrite_2DM        = 1'b0;
        dif.data_write_2DM      = '0;
        dif.data_write_size_2DM = '0;
        dif.dBlkRead            = 1'b0;
        dif.dBlkWrite           = 1'b0;
        dif.block_write_2DM     = '0;
        last_rd                 = '0;

        #2;
        chk("rst_rvld", dif.block_read_fDM_valid, 1'b0);
        chk("rst_wvld", dif.block_write_fDM_valid, 1'b0);
        chk("rst_blk", dif.block_read_fDM, 256'h0);
        chk("rst_word", dif.data_read_fDM, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < NW; i++) begin
            set_wr(32'(i) * 4, $urandom(), 2'd0);
            cyc(0, 0, '0);
        end

        // Full-word write then read, and read disabled.
        set_wr(32'h40, 32'hDEADBEEF, 2'd0);
        cyc(0, 0, '0);
        word_rd_chk("w_full", 32'h40);
        chk("w_full_lit", mem_m[widx(32'h40)], 32'hDEADBEEF);

        // Two-byte write at offset 3: upper byte falls off the word.
        set_wr(32'h40, 32'h11223344, 2'd0);
        cyc(0, 0, '0);
        set_wr(32'h43, 32'h0000ABCD, 2'd2);
        cyc(0, 0, '0);
        dif.data_address_2DM = 32'h40;
        dif.MemRead_2DM      = 1'b1;
        #1;
        chk("w_edge", dif.data_read_fDM, 32'hCD223344);
        dif.MemRead_2DM = 1'b0;

        // Block write then read back, pattern 1..8.
        for (int w = 0; w < 8; w++) pat[32*w +: 32] = 32'(w + 1);
        blk_op(1, 0, 32'h80, pat, 0, 0, 0, 0, "bw80");
        blk_op(0, 0, 32'h80, '0, 0, 0, 0, 0, "br80");
        chk("br80_lit", last_rd, pat);

        // Simultaneous write+read: write wins, read follows with new data.
        bd = rand_blk();
        blk_op(1, 1, 32'h20, bd, 0, 0, 0, 0, "both_w");
        blk_op(0, 0, 32'h20, '0, 0, 0, 0, 0, "both_r");
        chk("both_lit", last_rd, bd);

        // Reset in the middle of a block write abandons it.
        prior = m_blk(widx(32'h100) / 8);
        dif.data_address_2DM = 32'h100;
        dif.block_write_2DM  = ~prior;
        dif.dBlkWrite        = 1'b1;
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        RESET = 1'b0;
        #1;
        chk("midrst_vld", {dif.block_read_fDM_valid, dif.block_write_fDM_valid}, 2'b00);
        chk("midrst_blk", dif.block_read_fDM, 256'h0);
        last_rd = '0;
        dif.dBlkWrite = 1'b0;
        cyc(0, 0, '0);
        RESET = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            cyc(0, 0, '0);
            chk("midrst_quiet", {dif.block_read_fDM_valid, dif.block_write_fDM_valid}, 2'b00);
        end
        blk_op(0, 0, 32'h100, '0, 0, 0, 0, 0, "midrst_rd");
        chk("midrst_prior", last_rd, prior);

        // Word write during a block read's BUSY shows in the returned block.
        blk_op(0, 0, 32'h80, '0, 0, 2, 32'h84, 32'h55, "wr_in_busy");
        chk("wr_in_busy_w1", last_rd[63:32], 32'h00000055);

        // Word write on the block-write commit edge wins for that word.
        bd = rand_blk();
        blk_op(1, 0, 32'h60, bd, 0, LAT + 1, 32'h6C, 32'hA5A5_5A5A, "collide_w");
        blk_op(0, 0, 32'h60, '0, 0, 0, 0, 0, "collide_r");
        chk("collide_w3", last_rd[127:96], 32'hA5A5_5A5A);
        chk("collide_w0", last_rd[31:0], bd[31:0]);

        // Random mix, including aliased high address bits.
        for (int it = 0; it < 60; it++) begin
            ra = $urandom();
            case ($urandom_range(0, 4))
                0: begin
                    set_wr(ra, $urandom(), 2'($urandom_range(0, 3)));
                    cyc(0, 0, '0);
                end
                1: word_rd_chk("rnd_word", ra);
                2: blk_op(1, 0, ra, rand_blk(), 1, 0, 0, 0, "rnd_bw");
                3: blk_op(0, 0, ra, '0, 1, 0, 0, 0, "rnd_br");
                default: begin
                    bd = rand_blk();
                    blk_op(1, 1, ra, bd, 1, 0, 0, 0, "rnd_both_w");
                    blk_op(0, 0, ra, '0, 1, 0, 0, 0, "rnd_both_r");
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
